// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam int         FRAME_BITS = 11;   // start + 8 data + parity + stop

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-FF synchronisers on both lines, a glitch filter on
// ps2_clk and a one-cycle strobe on each filtered falling edge. data is the
// synchronised ps2_data, aligned so it is valid in the same cycle as fall.
module ps2_line_sync #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt;
   logic [CW-1:0] cnt;

   // Two-stage synchronisers; idle level of both lines is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt <= 1'b1;
         cnt  <= '0;
         fall <= 1'b0;
         data <= 1'b1;
      end else begin
         fall <= 1'b0;
         data <= data_sync[1];
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= clk_sync[1];
            cnt  <= '0;
            fall <= filt;            // old level high means this is a 1->0 change
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit device-to-host frames and resolves
// E0/F0 prefixes into make/break events.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the
// currently held key.
//
// Output semantics: key_valid, key_released and frame_err are single-cycle
// strobes with no back-pressure; key_code and key_extended are valid in the
// strobe cycle and stay stable until the next event. A consumer must sample on
// the strobe cycle, there is no ready.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_released,
   output logic       key_extended,
   output logic       frame_err
);

   import ps2_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          sdata;
   frame_state_t  state, state_nxt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic [TW-1:0] to_cnt;
   logic          good, bad, timeout;
   logic          byte_rdy;
   logic          ext, brk;
   logic          is_prefix;
   logic          repeat_hit;

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .data     (sdata)
   );

   // Frame state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; timeout outranks a (simultaneous-free) fall.
   always_comb begin
      state_nxt = state;
      good      = 1'b0;
      bad       = 1'b0;
      timeout   = 1'b0;
      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         timeout   = 1'b1;
         state_nxt = IDLE;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!sdata) state_nxt = DATA;
               else        bad       = 1'b1;
            end
            DATA: begin
               if (bit_cnt == 3'(FRAME_BITS - 4)) state_nxt = PARITY;
            end
            PARITY: state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               if (sdata && ((^shift) ^ par_bit)) good = 1'b1;
               else                              bad  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Frame datapath: bit counter, shift register, parity, timeout counter, strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt   <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         to_cnt    <= '0;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         to_cnt    <= (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
         byte_rdy  <= good;
         frame_err <= bad | timeout;
         if (fall && !timeout) begin
            case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shift   <= {sdata, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_bit <= sdata;
               default: ;
            endcase
         end
      end
   end

   assign is_prefix = (shift == PS2_EXT) || (shift == PS2_BREAK);

`ifdef PS2_REPEAT_FILTER_EN
   logic       held;
   logic [8:0] held_key;

   assign repeat_hit = held && (held_key == {ext, shift});

   // Track the last pressed key until its break arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held     <= 1'b0;
         held_key <= '0;
      end else if (byte_rdy && !timeout && !is_prefix) begin
         if (brk) begin
            if (repeat_hit) held <= 1'b0;
         end else if (!repeat_hit) begin
            held     <= 1'b1;
            held_key <= {ext, shift};
         end
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   // Scan-code decode: accumulate prefixes, emit one make/break strobe per key byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext          <= 1'b0;
         brk          <= 1'b0;
         key_code     <= '0;
         key_extended <= 1'b0;
         key_valid    <= 1'b0;
         key_released <= 1'b0;
      end else begin
         key_valid    <= 1'b0;
         key_released <= 1'b0;
         if (timeout) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_rdy) begin
            if (shift == PS2_EXT) begin
               ext <= 1'b1;
            end else if (shift == PS2_BREAK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (brk) begin
                  key_code     <= shift;
                  key_extended <= ext;
                  key_released <= 1'b1;
               end else if (!repeat_hit) begin
                  key_code     <= shift;
                  key_extended <= ext;
                  key_valid    <= 1'b1;
               end
            end
         end
      end
   end

endmodule
